mem_burst_responder: RTL and testbench

Memory-side responder for the cache controller's refill interface. Accepts a single-cycle line request, then returns the four words of the addressed line critical-word-first with wrap-around, one word per `ack_mem2cc` beat, after a programmable first-word latency. Sits between the cache controller and the backing word array, and serves as both the simulation memory model and the synthesizable main-memory front end. A side write port preloads and updates the array.

---
 rtl/cache_pkg.sv | 21 ++
 rtl/mem_burst_responder_if.sv | 28 ++
 rtl/mem_word_array.sv | 27 ++
 rtl/mem_burst_responder.sv | 121 ++++++++++++
 tb/tb_mem_burst_responder.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the cache refill path: bus widths, address field
// positions and the burst responder state encoding.
package cache_pkg;

  localparam int WORD_WIDTH = 32;
  localparam int ADR_WIDTH  = 32;
  localparam int WORD_NUM   = 4;

  // Byte address fields: [1:0] byte offset, [3:2] word in line, line from bit 4.
  localparam int WORD_LSB = 2;
  localparam int WORD_MSB = 3;
  localparam int LINE_LSB = 4;

  typedef logic [1:0] resp_state_t;

  localparam resp_state_t S_IDLE = 2'd0;
  localparam resp_state_t S_WAIT = 2'd1;
  localparam resp_state_t S_BEAT = 2'd2;
  localparam resp_state_t S_GAP  = 2'd3;

endpackage

// File: rtl/mem_burst_responder_if.sv
// Refill bus between the cache controller (master) and the memory responder
// (slave), plus the side write port used to preload and update the array.
interface mem_burst_responder_if #(
  parameter int WORD_WIDTH = cache_pkg::WORD_WIDTH,
  parameter int ADR_WIDTH  = cache_pkg::ADR_WIDTH
);

  logic                  req_cc2mem;
  logic [ADR_WIDTH-1:0]  adr_cc2mem;
  logic                  ack_mem2cc;
  logic [WORD_WIDTH-1:0] dat_mem2cc;
  logic                  wr_en;
  logic [ADR_WIDTH-1:0]  wr_adr;
  logic [WORD_WIDTH-1:0] wr_dat;
  logic                  busy;
  logic                  drop_err;

  modport master (
    output req_cc2mem, adr_cc2mem, wr_en, wr_adr, wr_dat,
    input  ack_mem2cc, dat_mem2cc, busy, drop_err
  );

  modport slave (
    input  req_cc2mem, adr_cc2mem, wr_en, wr_adr, wr_dat,
    output ack_mem2cc, dat_mem2cc, busy, drop_err
  );

endinterface

// File: rtl/mem_word_array.sv
// Word array with one synchronous read port and one synchronous write port;
// a same-edge read of the word being written returns the old contents.
module mem_word_array #(
  parameter  int WORD_WIDTH = 32,
  parameter  int MEM_WORDS  = 4096,
  localparam int IDX_W      = $clog2(MEM_WORDS)
) (
  input  logic                  clk,
  input  logic                  rd_en,
  input  logic [IDX_W-1:0]      rd_adr,
  output logic [WORD_WIDTH-1:0] rd_dat,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_adr,
  input  logic [WORD_WIDTH-1:0] wr_dat
);

  logic [WORD_WIDTH-1:0] mem [MEM_WORDS];

  // NOTE: the array and its read register carry no reset so they map onto
  // block RAM; both updates are non-blocking, which is what yields old data
  // when a read and a write hit the same word on one edge.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_adr] <= wr_dat;
    if (rd_en) rd_dat <= mem[rd_adr];
  end

endmodule

// File: rtl/mem_burst_responder.sv
// Memory-side refill responder: returns a 4-word line critical-word-first with
// wrap-around after a programmable first-word latency and inter-beat gap.
module mem_burst_responder #(
  parameter int WORD_WIDTH    = cache_pkg::WORD_WIDTH,
  parameter int ADR_WIDTH     = cache_pkg::ADR_WIDTH,
  parameter int MEM_WORDS     = 4096,
  parameter int WORD_NUM      = cache_pkg::WORD_NUM,
  parameter int FIRST_LATENCY = 4,
  parameter int BEAT_GAP      = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_burst_responder_if.slave  bus
);
  import cache_pkg::*;

  localparam int IDX_W   = $clog2(MEM_WORDS);
  localparam int LINE_W  = IDX_W - 2;
  localparam int CNT_MAX = (FIRST_LATENCY > BEAT_GAP) ? FIRST_LATENCY : BEAT_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  resp_state_t       state_q, state_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [LINE_W-1:0] line_q, line_n;
  logic [1:0]        start_q, start_n;
  logic [1:0]        k_q, k_n;
  logic [1:0]        word_n;
  logic              drop_q;
  logic              rd_en;
  logic [IDX_W-1:0]  rd_adr;
  logic [WORD_WIDTH-1:0] rd_dat;

  // NOTE: every next-state variable is defaulted to its current value first,
  // so no path through the case statement can infer a latch.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    line_n  = line_q;
    start_n = start_q;
    k_n     = k_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_cc2mem) begin
          line_n  = bus.adr_cc2mem[IDX_W+1:LINE_LSB];
          start_n = bus.adr_cc2mem[WORD_MSB:WORD_LSB];
          k_n     = 2'd0;
          if (FIRST_LATENCY == 1) begin
            state_n = S_BEAT;
          end else begin
            state_n = S_WAIT;
            cnt_n   = CNT_W'(FIRST_LATENCY - 1);
          end
        end
      end
      S_WAIT, S_GAP: begin
        if (cnt_q == CNT_W'(1)) state_n = S_BEAT;
        else                    cnt_n   = cnt_q - 1'b1;
      end
      S_BEAT: begin
        k_n = k_q + 2'd1;
        if (k_q == 2'(WORD_NUM - 1)) begin
          state_n = S_IDLE;
        end else if (BEAT_GAP > 0) begin
          state_n = S_GAP;
          cnt_n   = CNT_W'(BEAT_GAP);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // The array is read on the edge that enters BEAT, so the registered read
  // data lines up with the cycle in which ack is shown.
  assign word_n = start_n + k_n;
  assign rd_en  = (state_n == S_BEAT);
  assign rd_adr = {line_n, word_n};

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      start_q <= '0;
      k_q     <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      line_q  <= line_n;
      start_q <= start_n;
      k_q     <= k_n;
      if (bus.req_cc2mem && state_q != S_IDLE) drop_q <= 1'b1;
    end
  end

  mem_word_array #(
    .WORD_WIDTH (WORD_WIDTH),
    .MEM_WORDS  (MEM_WORDS)
  ) u_array (
    .clk    (clk),
    .rd_en  (rd_en),
    .rd_adr (rd_adr),
    .rd_dat (rd_dat),
    .wr_en  (bus.wr_en),
    .wr_adr (bus.wr_adr[IDX_W+1:WORD_LSB]),
    .wr_dat (bus.wr_dat)
  );

  assign bus.ack_mem2cc = (state_q == S_BEAT);
  assign bus.dat_mem2cc = (state_q == S_BEAT) ? rd_dat : '0;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.drop_err   = drop_q;

  // Address bits above the array index and the byte offset alias by design.
  logic unused_adr_bits;
  assign unused_adr_bits = ^{bus.adr_cc2mem[ADR_WIDTH-1:IDX_W+2], bus.adr_cc2mem[WORD_LSB-1:0],
                             bus.wr_adr[ADR_WIDTH-1:IDX_W+2], bus.wr_adr[WORD_LSB-1:0]};

endmodule

// File: tb/tb_mem_burst_responder.sv
// Bench for mem_burst_responder: three configurations checked every cycle
// against a timing-formula model, plus literal expectations on key beats.
module tb_mem_burst_responder;

  localparam int N = 3;

  function automatic int lat_of(input int i);
    return (i == 2) ? 1 : 4;
  endfunction

  function automatic int gap_of(input int i);
    return (i == 1) ? 2 : 0;
  endfunction

  logic        clk = 1'b0;
  logic        rst;
  logic        req    [N];
  logic [31:0] adr    [N];
  logic        wr_en  [N];
  logic [31:0] wr_adr [N];
  logic [31:0] wr_dat [N];
  logic        ack    [N];
  logic [31:0] dat    [N];
  logic        busy   [N];
  logic        drop   [N];

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < N; g++) begin : g_dut
      mem_burst_responder_if bus ();
      mem_burst_responder #(
        .FIRST_LATENCY (lat_of(g)),
        .BEAT_GAP      (gap_of(g))
      ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
      );
      assign bus.req_cc2mem = req[g];
      assign bus.adr_cc2mem = adr[g];
      assign bus.wr_en      = wr_en[g];
      assign bus.wr_adr     = wr_adr[g];
      assign bus.wr_dat     = wr_dat[g];
      assign ack[g]  = bus.ack_mem2cc;
      assign dat[g]  = bus.dat_mem2cc;
      assign busy[g] = bus.busy;
      assign drop[g] = bus.drop_err;
    end
  endgenerate

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;   // number of the last clock edge; the current cycle is cyc+1
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h want %h", name, cyc + 1, got, want);
    end
  endtask

  // Model: a request sampled at edge t shows beat n in cycle t+lat+n*(gap+1);
  // busy covers cycles t+1 .. t+lat+3*(gap+1).
  logic [31:0] mmem     [N][4096];
  bit          act      [N];
  int          t_acc    [N];
  int          base     [N];
  bit          drop_m   [N];
  logic        exp_ack  [N];
  logic [31:0] exp_dat  [N];
  logic        exp_busy [N];
  logic        exp_drop [N];

  initial begin
    for (int i = 0; i < N; i++) begin
      act[i] = 1'b0; t_acc[i] = 0; base[i] = 0; drop_m[i] = 1'b0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < N; i++) begin
        int lat, gp, last, nxt, idx;
        lat = lat_of(i);
        gp  = gap_of(i);
        if (rst) begin
          act[i] = 1'b0; drop_m[i] = 1'b0;
          exp_ack[i] = 1'b0; exp_dat[i] = '0; exp_busy[i] = 1'b0; exp_drop[i] = 1'b0;
          chk_en = 1'b1;
        end else begin
          last = t_acc[i] + lat + 3 * (gp + 1);
          if (req[i]) begin
            if (act[i] && cyc > t_acc[i] && cyc <= last) drop_m[i] = 1'b1;
            else begin
              act[i] = 1'b1; t_acc[i] = cyc; base[i] = int'(adr[i][13:2]);
            end
          end
          last = t_acc[i] + lat + 3 * (gp + 1);
          nxt  = cyc + 1;
          exp_busy[i] = act[i] && nxt > t_acc[i] && nxt <= last;
          exp_ack[i]  = 1'b0;
          exp_dat[i]  = '0;
          for (int n = 0; n < 4; n++) begin
            if (act[i] && nxt == t_acc[i] + lat + n * (gp + 1)) begin
              idx = (base[i] & ~3) | ((base[i] + n) & 3);
              exp_ack[i] = 1'b1;
              exp_dat[i] = mmem[i][idx];
            end
          end
          exp_drop[i] = drop_m[i];
        end
        if (wr_en[i]) mmem[i][wr_adr[i][13:2]] = wr_dat[i];
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < N; i++) begin
          check($sformatf("model ack[%0d]", i),  32'(ack[i]),  32'(exp_ack[i]));
          check($sformatf("model dat[%0d]", i),  dat[i],       exp_dat[i]);
          check($sformatf("model busy[%0d]", i), 32'(busy[i]), 32'(exp_busy[i]));
          check($sformatf("model drop[%0d]", i), 32'(drop[i]), 32'(exp_drop[i]));
        end
      end
    end
  end

  task automatic wait_cycle(input int c);
    while (cyc + 1 < c) @(negedge clk);
  endtask

  task automatic pulse_req(input int i, input logic [31:0] a, output int t);
    req[i] = 1'b1;
    adr[i] = a;
    t = cyc + 1;
    @(negedge clk);
    req[i] = 1'b0;
  endtask

  task automatic expect_beat(input string nm, input int i, input int c, input logic [31:0] d);
    wait_cycle(c);
    check({nm, " ack"}, 32'(ack[i]), 32'd1);
    check({nm, " dat"}, dat[i], d);
  endtask

  initial begin
    int t, t2;
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      req[i] = 1'b0; adr[i] = '0; wr_en[i] = 1'b0; wr_adr[i] = '0; wr_dat[i] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset ack", 32'(ack[0]), 32'd0);
    check("reset dat", dat[1], 32'd0);
    check("reset busy", 32'(busy[2]), 32'd0);
    check("reset drop", 32'(drop[0]), 32'd0);

    // Preload lines 4..7 in every instance: word w holds 0x1000_0000 + w.
    for (int w = 16; w < 32; w++) begin
      for (int i = 0; i < N; i++) begin
        wr_en[i] = 1'b1; wr_adr[i] = 32'(w * 4); wr_dat[i] = 32'h1000_0000 + 32'(w);
      end
      @(negedge clk);
    end
    for (int i = 0; i < N; i++) wr_en[i] = 1'b0;
    repeat (2) @(negedge clk);

    // Latency 4, no gap, critical word 2.
    pulse_req(0, 32'h58, t);
    wait_cycle(t + 3);
    check("lat4 no early ack", 32'(ack[0]), 32'd0);
    expect_beat("lat4 b0", 0, t + 4, 32'h1000_0016);
    expect_beat("lat4 b1", 0, t + 5, 32'h1000_0017);
    expect_beat("lat4 b2", 0, t + 6, 32'h1000_0014);
    expect_beat("lat4 b3", 0, t + 7, 32'h1000_0015);
    check("lat4 busy at b3", 32'(busy[0]), 32'd1);
    wait_cycle(t + 8);
    check("lat4 busy falls", 32'(busy[0]), 32'd0);

    // Gap 2, critical word 0.
    pulse_req(1, 32'h50, t);
    expect_beat("gap b0", 1, t + 4, 32'h1000_0014);
    wait_cycle(t + 5);
    check("gap idle ack", 32'(ack[1]), 32'd0);
    expect_beat("gap b1", 1, t + 7,  32'h1000_0015);
    expect_beat("gap b2", 1, t + 10, 32'h1000_0016);
    expect_beat("gap b3", 1, t + 13, 32'h1000_0017);
    check("gap busy at b3", 32'(busy[1]), 32'd1);
    wait_cycle(t + 14);
    check("gap busy falls", 32'(busy[1]), 32'd0);

    // Upper address bits and byte offset alias onto line 5, word 2.
    pulse_req(1, 32'h4000_005B, t);
    expect_beat("alias b0", 1, t + 4, 32'h1000_0016);
    wait_cycle(t + 15);

    // Request mid-burst is dropped and the sticky error sets.
    pulse_req(0, 32'h50, t);
    wait_cycle(t + 3);
    req[0] = 1'b1; adr[0] = 32'h58;
    @(negedge clk);
    req[0] = 1'b0;
    expect_beat("drop b0", 0, t + 4, 32'h1000_0014);
    check("drop err set", 32'(drop[0]), 32'd1);
    expect_beat("drop b3", 0, t + 7, 32'h1000_0017);
    wait_cycle(t + 20);
    check("drop err held", 32'(drop[0]), 32'd1);

    // Write on the edge that samples beat 0 of word 0x15: old data returned.
    pulse_req(0, 32'h54, t);
    wait_cycle(t + 3);
    wr_en[0] = 1'b1; wr_adr[0] = 32'h54; wr_dat[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    wr_en[0] = 1'b0;
    expect_beat("collide b0", 0, t + 4, 32'h1000_0015);
    expect_beat("collide b1", 0, t + 5, 32'h1000_0016);
    wait_cycle(t + 8);
    pulse_req(0, 32'h54, t);
    expect_beat("rewrite b0", 0, t + 4, 32'hDEAD_BEEF);
    wait_cycle(t + 8);

    // Reset between beat 1 and beat 2 aborts the burst; data survives.
    pulse_req(0, 32'h50, t);
    expect_beat("abort b0", 0, t + 4, 32'h1000_0014);
    expect_beat("abort b1", 0, t + 5, 32'hDEAD_BEEF);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort ack", 32'(ack[0]), 32'd0);
    check("abort dat", dat[0], 32'd0);
    check("abort busy", 32'(busy[0]), 32'd0);
    check("abort drop cleared", 32'(drop[0]), 32'd0);
    repeat (3) @(negedge clk);
    check("abort no late ack", 32'(ack[0]), 32'd0);
    pulse_req(0, 32'h58, t);
    expect_beat("post rst b0", 0, t + 4, 32'h1000_0016);
    expect_beat("post rst b3", 0, t + 7, 32'hDEAD_BEEF);
    wait_cycle(t + 8);

    // Latency 1: beat 0 the cycle after the request; back-to-back spacing.
    pulse_req(2, 32'h5C, t);
    expect_beat("lat1 b0", 2, t + 1, 32'h1000_0017);
    expect_beat("lat1 b1", 2, t + 2, 32'h1000_0014);
    expect_beat("lat1 b2", 2, t + 3, 32'h1000_0015);
    expect_beat("lat1 b3", 2, t + 4, 32'h1000_0016);
    wait_cycle(t + 5);
    pulse_req(2, 32'h50, t2);
    expect_beat("lat1 next b0", 2, t2 + 1, 32'h1000_0014);
    check("lat1 no drop", 32'(drop[2]), 32'd0);
    wait_cycle(t2 + 4);
    req[2] = 1'b1; adr[2] = 32'h58;
    @(negedge clk);
    req[2] = 1'b0;
    check("lat1 beat3 req dropped ack", 32'(ack[2]), 32'd0);
    check("lat1 beat3 req drop err", 32'(drop[2]), 32'd1);
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
